data_bus_adapter: RTL and testbench

//  Sequential stage directly downstream of the load/store controller, between it and the data memory.

---
 rtl/data_bus_adapter.sv | 127 ++++++++++++
 tb/tb_data_bus_adapter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_adapter.sv
// Bridges one load/store access at a time onto a valid/ready command bus with an
// ack response, holding the pipeline until the access completes or times out.
module data_bus_adapter #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TIMEOUT_EN     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [29:0] req_addr,
  input  logic [3:0]  req_mask,
  input  logic [31:0] req_wdata,
  output logic        req_stall,
  output logic        rsp_valid,
  output logic        rsp_error,
  output logic [31:0] rsp_rdata,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [29:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, CMD, WAIT, DONE} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          bus_valid_q, bus_we_q, rsp_valid_q, rsp_error_q;
  logic [29:0]   addr_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q, rdata_q;
  logic          timeout_hit;

  assign timeout_hit = (TIMEOUT_EN != 0) && (cnt_q >= CW'(TIMEOUT_CYCLES - 1));

  // Stall rises combinationally with the request so the controller holds it that cycle.
  always_comb begin
    req_stall = 1'b0;
    case (state_q)
      IDLE:      req_stall = req_read | req_write;
      CMD, WAIT: req_stall = 1'b1;
      default:   req_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_read && req_write) begin
            state_q     <= DONE;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 1'b1;
          end else if (req_write && req_mask == 4'b0000) begin
            // empty-mask store completes silently without touching the bus
            state_q     <= DONE;
            rsp_valid_q <= 1'b1;
          end else if (req_read || req_write) begin
            state_q     <= CMD;
            cnt_q       <= '0;
            bus_valid_q <= 1'b1;
            bus_we_q    <= req_write;
            addr_q      <= req_addr;
            be_q        <= req_write ? req_mask : 4'b1111;
            wdata_q     <= req_wdata;
          end
        end
        CMD: begin
          cnt_q <= cnt_q + CW'(1);
          if (bus_ready) begin
            state_q     <= WAIT;
            bus_valid_q <= 1'b0;
          end else if (timeout_hit) begin
            state_q     <= DONE;
            bus_valid_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 1'b1;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          if (bus_ack) begin
            state_q     <= DONE;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= bus_err;
            if (!bus_we_q && !bus_err) rdata_q <= bus_rdata;
          end else if (timeout_hit) begin
            state_q     <= DONE;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_error = rsp_error_q;
  assign rsp_rdata = rdata_q;
  assign bus_valid = bus_valid_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_data_bus_adapter.sv
// Directed plus randomized accesses against a per-transaction timing model;
// a second instance with a short timeout covers the forced-completion path.
module tb_data_bus_adapter;

  logic        clk, rst_n;
  logic        req_read, req_write, t_req_read;
  logic [29:0] req_addr;
  logic [3:0]  req_mask;
  logic [31:0] req_wdata;
  logic        bus_ready, bus_ack, bus_err;
  logic [31:0] bus_rdata;

  logic        req_stall, rsp_valid, rsp_error, bus_valid, bus_we;
  logic [31:0] rsp_rdata, bus_wdata;
  logic [29:0] bus_addr;
  logic [3:0]  bus_be;

  logic        t_req_stall, t_rsp_valid, t_rsp_error, t_bus_valid, t_bus_we;
  logic [31:0] t_rsp_rdata, t_bus_wdata;
  logic [29:0] t_bus_addr;
  logic [3:0]  t_bus_be;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_rdata = '0;

  data_bus_adapter dut (
    .clk(clk), .rst_n(rst_n),
    .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
    .req_mask(req_mask), .req_wdata(req_wdata),
    .req_stall(req_stall), .rsp_valid(rsp_valid), .rsp_error(rsp_error),
    .rsp_rdata(rsp_rdata), .bus_valid(bus_valid), .bus_ready(bus_ready),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
  );

  data_bus_adapter #(.TIMEOUT_CYCLES(4), .TIMEOUT_EN(1)) dut_to (
    .clk(clk), .rst_n(rst_n),
    .req_read(t_req_read), .req_write(1'b0), .req_addr(req_addr),
    .req_mask(req_mask), .req_wdata(req_wdata),
    .req_stall(t_req_stall), .rsp_valid(t_rsp_valid), .rsp_error(t_rsp_error),
    .rsp_rdata(t_rsp_rdata), .bus_valid(t_bus_valid), .bus_ready(bus_ready),
    .bus_we(t_bus_we), .bus_addr(t_bus_addr), .bus_be(t_bus_be), .bus_wdata(t_bus_wdata),
    .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One access: request at c=0, ready after rdly CMD cycles, ack adly cycles into WAIT.
  task automatic access(input bit rd, input bit wr, input logic [29:0] a,
                        input logic [3:0] m, input logic [31:0] wd,
                        input int rdly, input int adly, input bit e,
                        input logic [31:0] rdat, input string tag);
    bit legal, usebus, in_cmd, in_wait, ack_now;
    int done_c;
    legal  = rd ^ wr;
    usebus = legal && !(wr && m == 4'b0000);
    done_c = usebus ? 3 + rdly + adly : 1;
    for (int c = 0; c <= done_c; c++) begin
      if (c == 0) begin
        req_read = rd; req_write = wr; req_addr = a; req_mask = m; req_wdata = wd;
      end
      if (c == done_c) begin
        req_read = 1'b0; req_write = 1'b0; req_addr = $urandom; req_wdata = $urandom;
      end
      in_cmd    = usebus && c >= 1 && c <= 1 + rdly;
      in_wait   = usebus && c >= 2 + rdly && c < done_c;
      ack_now   = in_wait && c == 2 + rdly + adly;
      bus_ready = usebus && c == 1 + rdly;
      bus_ack   = ack_now ? 1'b1 : (in_cmd ? 1'($urandom % 2) : 1'b0);
      bus_err   = ack_now ? e : 1'($urandom % 2);
      bus_rdata = ack_now ? rdat : $urandom;
      @(negedge clk);
      chk({tag, ".stall"}, 32'(req_stall), 32'(c < done_c));
      chk({tag, ".bvalid"}, 32'(bus_valid), 32'(in_cmd));
      chk({tag, ".rvalid"}, 32'(rsp_valid), 32'(c == done_c));
      if (in_cmd) begin
        chk({tag, ".addr"}, 32'(bus_addr), 32'(a));
        chk({tag, ".be"}, 32'(bus_be), 32'(rd ? 4'b1111 : m));
        chk({tag, ".we"}, 32'(bus_we), 32'(wr));
        if (wr) chk({tag, ".wdata"}, bus_wdata, wd);
      end
      if (c == done_c) begin
        chk({tag, ".err"}, 32'(rsp_error), 32'(!legal || (usebus && e)));
        if (rd && legal && !e) exp_rdata = rdat;
      end else begin
        chk({tag, ".err0"}, 32'(rsp_error), 32'd0);
      end
      chk({tag, ".rdata"}, rsp_rdata, exp_rdata);
      next_cycle();
    end
    bus_ready = 1'b0; bus_ack = 1'b0; bus_err = 1'b0;
  endtask

  // Async reset landing in CMD (at_c=1) or WAIT (at_c=2) of a load.
  task automatic reset_mid(input int at_c);
    req_read = 1'b1; req_addr = 30'h155; req_mask = 4'h0;
    next_cycle();
    bus_ready = (at_c == 2);
    if (at_c == 2) next_cycle();
    bus_ready = 1'b0;
    #1;
    rst_n = 1'b0; req_read = 1'b0;
    #1;
    exp_rdata = '0;
    chk("rst_mid.bvalid", 32'(bus_valid), 32'd0);
    chk("rst_mid.stall", 32'(req_stall), 32'd0);
    chk("rst_mid.rdata", rsp_rdata, 32'd0);
    chk("rst_mid.addr", 32'(bus_addr), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid.no_rsp", 32'(rsp_valid), 32'd0);
      next_cycle();
      bus_ack = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; req_read = 1'b0; req_write = 1'b0; t_req_read = 1'b0;
    req_addr = '0; req_mask = '0; req_wdata = '0;
    bus_ready = 1'b0; bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle.bvalid", 32'(bus_valid), 32'd0);
      chk("idle.rvalid", 32'(rsp_valid), 32'd0);
      next_cycle();
    end
    chk("idle.stall", 32'(req_stall), 32'd0);
    chk("idle.rerr", 32'(rsp_error), 32'd0);
    chk("idle.rdata", rsp_rdata, 32'd0);
    chk("idle.addr", 32'(bus_addr), 32'd0);
    chk("idle.be", 32'(bus_be), 32'd0);
    chk("idle.wdata", bus_wdata, 32'd0);
    chk("idle.we", 32'(bus_we), 32'd0);

    access(1, 0, 30'h10, 4'h0, 32'h0, 0, 0, 0, 32'hDEAD_BEEF, "load_min");
    access(0, 1, 30'h2A, 4'b0110, 32'h00AB_CD00, 3, 1, 0, 32'h0, "store_slow");
    access(0, 1, 30'h33, 4'b0000, 32'hFFFF_FFFF, 0, 0, 0, 32'h0, "store_nomask");
    access(1, 0, 30'h44, 4'h0, 32'h0, 1, 2, 1, 32'hBAD0_BAD0, "load_err");
    access(1, 1, 30'h55, 4'hF, 32'h0, 0, 0, 0, 32'h0, "illegal");
    access(1, 0, 30'h66, 4'h0, 32'h0, 2, 0, 0, 32'h0BAD_F00D, "load_2");

    for (int n = 0; n < 40; n++) begin
      int  k;
      bit  rd, wr;
      logic [3:0] m;
      k  = int'($urandom % 8);
      rd = (k == 0) || (k >= 2 && k < 5);
      wr = (k <= 1) || (k >= 5);
      m  = (k == 1) ? 4'h0 : 4'($urandom_range(1, 15));
      access(rd, wr, 30'($urandom), m, $urandom, int'($urandom % 5), int'($urandom % 4),
             1'($urandom % 4 == 0), $urandom, "rand");
      repeat ($urandom % 2) next_cycle();
    end

    // short-timeout instance: command never accepted
    t_req_read = 1'b1; req_addr = 30'h5; bus_ready = 1'b0;
    for (int c = 0; c <= 5; c++) begin
      if (c == 5) t_req_read = 1'b0;
      @(negedge clk);
      chk("tmo.bvalid", 32'(t_bus_valid), 32'(c >= 1 && c <= 4));
      chk("tmo.stall", 32'(t_req_stall), 32'(c < 5));
      chk("tmo.rvalid", 32'(t_rsp_valid), 32'(c == 5));
      if (c == 5) begin
        chk("tmo.err", 32'(t_rsp_error), 32'd1);
        chk("tmo.rdata", t_rsp_rdata, 32'd0);
      end
      next_cycle();
    end
    bus_ack = 1'b1; bus_rdata = 32'hCAFE_0000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("tmo.late_ack", 32'(t_rsp_valid), 32'd0);
      next_cycle();
      bus_ack = 1'b0;
    end

    reset_mid(1);
    access(1, 0, 30'h77, 4'h0, 32'h0, 0, 0, 0, 32'h1357_9BDF, "post_rst_cmd");
    reset_mid(2);
    access(1, 0, 30'h88, 4'h0, 32'h0, 1, 1, 0, 32'h2468_ACE0, "post_rst_wait");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
